// File: rtl/neuron_accumulator_pkg.sv
// Shared Q16.16 constants and the accumulator FSM state type.
package neuron_accumulator_pkg;

  localparam int unsigned FRAC_W = 16;
  localparam logic [31:0] Q_ONE  = 32'h0001_0000;
  localparam logic [31:0] Q_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_MIN  = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/q16_mul_sat.sv
// Q16.16 signed saturating multiplier (truncating), used unchanged by the accumulator.
module q16_mul_sat
  import neuron_accumulator_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_p
);

  logic signed [63:0] w_full;
  logic signed [63:0] w_shift;

  assign w_full  = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_shift = w_full >>> FRAC_W;

  always_comb begin
    if ((w_shift[63:31] == '0) || (w_shift[63:31] == '1)) begin
      o_p = w_shift[31:0];
    end else if (w_shift[63]) begin
      o_p = Q_MIN;
    end else begin
      o_p = Q_MAX;
    end
  end

endmodule

// File: rtl/sat_add32.sv
// Combinational 32-bit signed saturating adder; reusable by later layer blocks.
module sat_add32
  import neuron_accumulator_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum,
  output logic        o_clipped
);

  logic [32:0] w_sum;

  assign w_sum = {i_a[31], i_a} + {i_b[31], i_b};

  // Overflow shows up as disagreement between the guard bit and the sign bit.
  always_comb begin
    o_clipped = w_sum[32] ^ w_sum[31];
    if (!o_clipped) begin
      o_sum = w_sum[31:0];
    end else if (w_sum[32]) begin
      o_sum = Q_MIN;
    end else begin
      o_sum = Q_MAX;
    end
  end

endmodule

// File: rtl/neuron_accumulator.sv
// Streams N_INPUTS x/w pairs through a saturating multiply-accumulate onto a bias.
// Optional: define NEURON_RELU_EN to apply ReLU to the presented result.
module neuron_accumulator
  import neuron_accumulator_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_INPUTS = 784,
  parameter int unsigned CNT_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              sat,
  output logic              busy
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_prod_q;
  logic              r_prod_v;
  logic              r_sat;

  logic              w_hs;
  logic              w_last;
  logic              w_start_acc;
  logic [DATA_W-1:0] w_prod;
  logic [DATA_W-1:0] w_sum;
  logic              w_clip;

  // Handshake is derived from the state directly so it does not loop through in_ready.
  assign w_hs        = in_valid && (r_state == ACCUM);
  assign w_last      = w_hs && (r_cnt == CNT_W'(N_INPUTS - 1));
  assign w_start_acc = start && (r_state == IDLE);

  q16_mul_sat u_mul (
    .i_a (x),
    .i_b (w),
    .o_p (w_prod)
  );

  sat_add32 u_add (
    .i_a       (r_acc),
    .i_b       (r_prod_q),
    .o_sum     (w_sum),
    .o_clipped (w_clip)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (w_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!r_prod_v) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod_q <= '0;
      r_prod_v <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_prod_v <= w_hs;
      if (w_hs) r_prod_q <= w_prod;
      if (w_start_acc) begin
        r_cnt <= '0;
      end else if (w_hs) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (w_start_acc) begin
      r_acc <= bias;
      r_sat <= 1'b0;
    end else if (r_prod_v) begin
      r_acc <= w_sum;
      if (w_clip) r_sat <= 1'b1;
    end
  end

  assign sat = r_sat;

`ifdef NEURON_RELU_EN
  assign result = r_acc[DATA_W-1] ? '0 : r_acc;
`else
  assign result = r_acc;
`endif

endmodule

// File: tb/tb_neuron_accumulator.sv
// Scoreboard bench for neuron_accumulator with N_INPUTS=4 and hand-computed sums.
module tb_neuron_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] bias = '0;
  logic        in_valid = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] w = '0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;
  logic        sat;
  logic        busy;

  typedef struct packed {
    logic        s;
    logic [31:0] r;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   cyc    = 0;
  int   last_hs = 0;
  int   n_out  = 0;
  int   n_jobs = 0;
  logic prev_ov = 1'b0;

  neuron_accumulator #(
    .DATA_W   (32),
    .N_INPUTS (4),
    .CNT_W    (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w         (w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sat       (sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency of each result and scoreboard compare on every accepted output.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) last_hs = cyc;
      if (out_valid && !prev_ov) begin
        chk("out_expected", 32'(sb.size() != 0), 32'd1);
        chk("latency", 32'(cyc - last_hs), 32'd3);
      end
      if (out_valid && out_ready && (sb.size() != 0)) begin
        e_mon = sb.pop_front();
        chk("result", result, e_mon.r);
        chk("sat", 32'(sat), 32'(e_mon.s));
        n_out++;
      end
      prev_ov = out_valid;
    end
  end

  task automatic do_start(input logic [31:0] b);
    start = 1'b1;
    bias  = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] xv, input logic [31:0] wv);
    int k = 0;
    in_valid = 1'b1;
    x = xv;
    w = wv;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("pair_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 100);
    chk("job_finish", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 100);
    chk("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic run_job(input logic [31:0] b, input logic [3:0][31:0] xs,
                         input logic [3:0][31:0] ws, input logic [3:0] gaps,
                         input logic [31:0] er, input logic es);
    sb.push_back('{s: es, r: er});
    n_jobs++;
    do_start(b);
    for (int i = 0; i < 4; i++) begin
      if (gaps[i]) repeat (i + 1) begin
        @(posedge clk); #1;
      end
      send_pair(xs[i], ws[i]);
    end
    wait_done();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_sat"}, 32'(sat), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0][31:0] x_one, w_half, w_one, x_neg, x_mix, x_two, w_onehalf;
    logic [31:0]      relu_exp;
    x_one     = {4{32'h0001_0000}};
    w_half    = {4{32'h0000_8000}};
    w_one     = {4{32'h0001_0000}};
    x_neg     = {4{32'hFFFF_0000}};
    x_mix     = {32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    x_two     = {4{32'h0002_0000}};
    w_onehalf = {4{32'h0001_8000}};
`ifdef NEURON_RELU_EN
    relu_exp = 32'h0000_0000;
`else
    relu_exp = 32'hFFFE_0000;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4 x (1.0 * 0.5) = 2.0
    run_job(32'h0000_0000, x_one, w_half, 4'b0000, 32'h0002_0000, 1'b0);
    // 32767.0 + 1.0 clips on the first step and stays at max
    run_job(32'h7FFF_0000, x_one, w_one, 4'b0000, 32'h7FFF_FFFF, 1'b1);
    chk("sat_sticky_idle", 32'(sat), 32'd1);
    // -32767.0 - 4.0 clips to min
    run_job(32'h8001_0000, x_neg, w_one, 4'b0000, 32'h8000_0000, 1'b1);
    // -32767 -1 -1(clip) +1 +1: per-step clamp gives -32766.0
    run_job(32'h8001_0000, x_mix, w_one, 4'b0000, 32'h8002_0000, 1'b1);
    // zero weights leave the negative bias, optionally rectified
    run_job(32'hFFFE_0000, x_one, '0, 4'b0000, relu_exp, 1'b0);
    // input gaps must not change the sum
    run_job(32'h0000_0000, x_one, w_half, 4'b1011, 32'h0002_0000, 1'b0);

    // backpressure: result frozen while out_ready is low, pairs ignored in DONE
    out_ready = 1'b0;
    sb.push_back('{s: 1'b0, r: 32'h0002_0000});
    n_jobs++;
    do_start(32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      if (i == 1 || i == 3) repeat (3) begin
        @(posedge clk); #1;
      end
      send_pair(x_one[i], w_half[i]);
    end
    wait_out_valid();
    @(posedge clk); #1;
    in_valid = 1'b1;
    x = 32'h7FFF_0000;
    w = 32'h7FFF_0000;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", result, 32'h0002_0000);
      chk("bp_hold_sat", 32'(sat), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_done();

    // reset mid-job: partial sum discarded, no output produced
    sb.push_back('{s: 1'b0, r: 32'h0005_0002});
    do_start(32'h0005_0000);
    send_pair(32'h0001_0000, 32'h0001_0000);
    send_pair(32'h0001_0000, 32'h0001_0000);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    void'(sb.pop_back());
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_busy", 32'(busy), 32'd0);
    chk("abort_no_out", 32'(out_valid), 32'd0);
    // 1.0 + 4 x (2.0 * 1.5) = 13.0
    run_job(32'h0001_0000, x_two, w_onehalf, 4'b0000, 32'h000D_0000, 1'b0);

    // protocol abuse: in_valid in IDLE, start in ACCUM and in DONE
    in_valid = 1'b1;
    x = 32'h7FFF_0000;
    w = 32'h7FFF_0000;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back('{s: 1'b0, r: 32'h0004_8000});
    n_jobs++;
    do_start(32'h0000_8000);
    send_pair(32'h0001_0000, 32'h0001_0000);
    send_pair(32'h0001_0000, 32'h0001_0000);
    do_start(32'h7000_0000);
    send_pair(32'h0001_0000, 32'h0001_0000);
    send_pair(32'h0001_0000, 32'h0001_0000);
    out_ready = 1'b0;
    wait_out_valid();
    @(posedge clk); #1;
    start = 1'b1;
    bias  = 32'h1234_0000;
    @(negedge clk);
    chk("done_start_busy", 32'(busy), 32'd1);
    chk("done_start_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("exit_start_busy", 32'(busy), 32'd0);
    chk("exit_start_valid", 32'(out_valid), 32'd0);
    repeat (6) @(negedge clk);
    chk("exit_start_idle", 32'(busy), 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("one_out_per_start", 32'(n_out), 32'(n_jobs));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/neuron_accumulator.md
Name: neuron_accumulator

Overview:
- Dot-product stage directly downstream of the team's 32-bit Q16.16 saturating multiplier.
- Streams N_INPUTS (activation, weight) pairs through a valid/ready handshake and drives each pair into one multiplier instance.
- Registers each product, then accumulates it onto a bias with saturation.
- Presents one Q16.16 neuron pre-activation (or activation) per job to the next layer.

Parameters:
- DATA_W, 32, fixed-point word width (Q16.16, signed two's complement).
- N_INPUTS, 784, pairs accumulated per job (>=1).
- CNT_W, 10, input counter width; must satisfy 2**CNT_W > N_INPUTS.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  job start pulse; sampled only in IDLE.
- bias  in  DATA_W  Q16.16 bias; captured on accepted start.
- in_valid  in  1  x/w pair valid.
- in_ready  out  1  block accepts a pair this cycle.
- x  in  DATA_W  Q16.16 activation.
- w  in  DATA_W  Q16.16 weight.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  downstream accepts result.
- result  out  DATA_W  Q16.16 accumulated sum.
- sat  out  1  sticky: some accumulate step saturated during this job.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: in_ready=0, out_valid=0, result=0, sat=0, busy=0.
- Reset also clears internal state: state=IDLE, acc=0, cnt=0, pipeline valid=0.
- FSM states are IDLE, ACCUM, DRAIN, DONE.
- IDLE -> ACCUM on start: acc<=bias, cnt<=0, sat<=0.
- ACCUM:
  - in_ready=1.
  - Handshake = in_valid & in_ready. On a handshake, the multiplier output for x*w is registered into prod_q with prod_v<=1 (stage 1); cnt increments.
  - When the handshake makes cnt reach N_INPUTS: in_ready drops the next cycle and the FSM goes to DRAIN.
- Stage 2: when prod_v=1, acc <= sat_add(acc, prod_q); sets sat if clipped. This applies in any state.
- DRAIN: waits one cycle for the final prod_v to retire, then goes to DONE.
- DONE:
  - out_valid=1; result is driven from acc and held stable.
  - On out_valid & out_ready -> IDLE; out_valid drops next cycle.
- Latency: the handshake of the last pair is at cycle t; out_valid rises at t+3, and result is valid in that same cycle.
- sat_add:
  - 33-bit signed sum.
  - If > 0x7FFF_FFFF, clamp to 0x7FFF_FFFF; if < 0x8000_0000, clamp to 0x8000_0000.
  - Saturation is applied at every step, not only at the end.
- Multiplier saturation does not set sat.
- Boundary conditions:
  - in_valid outside ACCUM is ignored (in_ready=0).
  - start outside IDLE is ignored, including start in the same cycle as the DONE->IDLE transition.
  - in_valid low mid-job stalls the block with no state change; gaps are unlimited.
  - N_INPUTS=1 is legal: ACCUM lasts until the single handshake.
  - out_ready held low keeps result, sat and out_valid frozen indefinitely.
  - rst_n low at any time aborts the job immediately; the partial sum is discarded and no out_valid is produced.
- sat remains readable until the next accepted start.

Optional Feature:
- NEURON_RELU_EN defined:
  - result is driven as (acc[DATA_W-1] ? 0 : acc), i.e. ReLU applied combinationally on the registered acc.
  - Latency is unchanged; sat is unaffected by the clamp.
- Undefined: result = acc (raw pre-activation, may be negative).

Decomposition:
- Shared package:
  - Q16.16 constants: FRAC_W=16, Q_ONE=32'h0001_0000, Q_MAX=32'h7FFF_FFFF, Q_MIN=32'h8000_0000.
  - FSM state typedef: IDLE/ACCUM/DRAIN/DONE.
- Sub-module sat_add32: combinational saturating adder (a, b -> sum, clipped). It is reusable by later layer blocks.
- The multiplier is instantiated as-is; it is not modified.

Test Plan:
- Basic sum: N_INPUTS=4, bias=0, four pairs x=0x0001_0000, w=0x0000_8000 back-to-back -> result=0x0002_0000, sat=0, out_valid exactly 3 cycles after the 4th handshake.
- Saturation: N_INPUTS=4, bias=0x7FFF_0000, x=w=0x0001_0000 x4 -> result=0x7FFF_FFFF, sat=1. Repeat with a negative bias/product mix -> result=0x8000_0000.
- Backpressure: random in_valid gaps, then out_ready low 5 cycles after out_valid -> result/sat held stable; in_ready=0 throughout DONE. Same sum as the gap-free run.
- ReLU: bias=0xFFFE_0000, all w=0 -> result=0 with NEURON_RELU_EN; 0xFFFE_0000 without.
- Reset mid-job: rst_n low after 2 of 4 handshakes -> all outputs 0 immediately, busy=0. A fresh job afterwards gives the exact expected sum.
- Protocol abuse: start pulsed during ACCUM and DONE, and in_valid in IDLE -> no effect; cnt and acc are unchanged, and exactly one out_valid per accepted start.
